// File: rtl/oam_dma.sv
// ============================================================================
// Module   : oam_dma
// Purpose  : $4014 sprite DMA. Halts the CPU, copies CPU page P00..PFF into the
//            PPU OAMDATA register. OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN state.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oam_dma #(
  parameter int         P_count_bits = 8,
  parameter logic [2:0] P_oam_reg    = 3'd4
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic        I_tick_odd,
  input  logic        I_reg_wren,
  input  logic [7:0]  I_reg_data,
  output logic        O_cpu_halt,
  output logic        O_busy,
  output logic [15:0] O_mem_addr,
  output logic        O_mem_rden,
  input  logic [7:0]  I_mem_data,
  output logic [2:0]  O_ppu_addr,
  output logic        O_ppu_wren,
  output logic [7:0]  O_ppu_data
);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;
  logic unused_tick_odd;
  assign unused_tick_odd = I_tick_odd;
`endif

  localparam logic [P_count_bits-1:0] c_one = P_count_bits'(1);

  state_t                  state_q, state_d;
  logic [7:0]              page_q, page_d;
  logic [P_count_bits-1:0] count_q, count_d;
  logic [7:0]              byte_q, byte_d;
  logic                    busy_q, busy_d;
  logic                    rden_q, rden_d;
  logic                    wren_q, wren_d;
  logic [15:0]             mem_addr_q, mem_addr_d;
  logic [7:0]              ppu_data_q, ppu_data_d;
  logic [7:0]              offset_d;

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    count_d    = count_q;
    byte_d     = byte_q;
    case (state_q)
      S_IDLE: begin
        if (I_reg_wren) begin
          page_d  = I_reg_data;
          count_d = '0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (I_tick) begin
`ifdef OAM_DMA_ALIGN_EN
          state_d = I_tick_odd ? S_ALIGN : S_READ;
`else
          state_d = S_READ;
`endif
        end
      end
`ifdef OAM_DMA_ALIGN_EN
      S_ALIGN: begin
        if (I_tick) state_d = S_READ;
      end
`endif
      S_READ: begin
        if (I_tick) begin
          byte_d  = I_mem_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (I_tick) begin
          // The last byte terminates instead of wrapping the offset.
          if (&count_q) begin
            state_d = S_IDLE;
          end else begin
            count_d = count_q + c_one;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    offset_d   = 8'(count_d);
    busy_d     = (state_d != S_IDLE);
    rden_d     = (state_d == S_READ);
    wren_d     = (state_d == S_WRITE);
    mem_addr_d = (state_d == S_READ) ? {page_d, offset_d} : mem_addr_q;
    ppu_data_d = (state_d == S_WRITE) ? byte_d : ppu_data_q;
  end

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q    <= S_IDLE;
      page_q     <= '0;
      count_q    <= '0;
      byte_q     <= '0;
      busy_q     <= 1'b0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      mem_addr_q <= '0;
      ppu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      count_q    <= count_d;
      byte_q     <= byte_d;
      busy_q     <= busy_d;
      rden_q     <= rden_d;
      wren_q     <= wren_d;
      mem_addr_q <= mem_addr_d;
      ppu_data_q <= ppu_data_d;
    end
  end

  assign O_cpu_halt = busy_q;
  assign O_busy     = busy_q;
  assign O_mem_rden = rden_q;
  assign O_mem_addr = mem_addr_q;
  assign O_ppu_wren = wren_q;
  assign O_ppu_data = ppu_data_q;
  assign O_ppu_addr = P_oam_reg;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// ============================================================================
// Module   : tb_oam_dma
// Purpose  : Self-checking bench for oam_dma against a transfer-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        I_clock = 1'b0;
  logic        I_reset = 1'b0;
  logic        I_tick = 1'b0;
  logic        I_tick_odd = 1'b0;
  logic        I_reg_wren = 1'b0;
  logic [7:0]  I_reg_data = 8'h00;
  logic [7:0]  I_mem_data;
  logic        O_cpu_halt, O_busy, O_mem_rden, O_ppu_wren;
  logic [15:0] O_mem_addr;
  logic [2:0]  O_ppu_addr;
  logic [7:0]  O_ppu_data;

  oam_dma dut (
    .I_clock(I_clock), .I_reset(I_reset), .I_tick(I_tick), .I_tick_odd(I_tick_odd),
    .I_reg_wren(I_reg_wren), .I_reg_data(I_reg_data),
    .O_cpu_halt(O_cpu_halt), .O_busy(O_busy),
    .O_mem_addr(O_mem_addr), .O_mem_rden(O_mem_rden), .I_mem_data(I_mem_data),
    .O_ppu_addr(O_ppu_addr), .O_ppu_wren(O_ppu_wren), .O_ppu_data(O_ppu_data)
  );

  always #5 I_clock = ~I_clock;

  // CPU memory: low address byte XOR a per-transfer key.
  logic [7:0] key = 8'h00;
  function automatic logic [7:0] mem_fn(input logic [15:0] a, input logic [7:0] k);
    return a[7:0] ^ k;
  endfunction
  assign I_mem_data = mem_fn(O_mem_addr, key);

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observed traffic
  logic [15:0] rd_q[$];
  logic [10:0] wr_q[$];
  int          halt_ticks, first_rd, wren_clks;
  logic        prev_wren;

  // Apply inputs for the coming edge and record what that edge will consume.
  task automatic cyc(input logic tk, input logic wr, input logic [7:0] d, input logic odd);
    I_tick = tk; I_reg_wren = wr; I_reg_data = d; I_tick_odd = odd;
    if (tk && O_cpu_halt) halt_ticks++;
    if (tk && O_mem_rden) begin
      if (first_rd < 0) first_rd = halt_ticks;
      rd_q.push_back(O_mem_addr);
    end
    if (O_ppu_wren && !prev_wren) wr_q.push_back({O_ppu_addr, O_ppu_data});
    if (O_ppu_wren) wren_clks++;
    prev_wren = O_ppu_wren;
    @(negedge I_clock);
  endtask

  typedef struct {
    logic [7:0] page;
    logic [7:0] key;
    int         period;
    bit         odd;
    bit         trig_tick;
    int         disturb;
    int         rst_at;
  } vec_t;

  task automatic run(input int idx, input vec_t v);
    int  n;
    bit  disturbed, was_reset, tk, odd_now;
    int  exp_n, exp_rd_n, mism_rd, mism_wr, exp_ticks, exp_first;
    logic [15:0] ea;
    rd_q.delete(); wr_q.delete();
    halt_ticks = 0; first_rd = -1; wren_clks = 0; prev_wren = O_ppu_wren;
    key = v.key; disturbed = 0; was_reset = 0;
    cyc(v.trig_tick, 1'b1, v.page, 1'($urandom));
    n = 1;
    while ((O_busy || n < 2) && n < 20000 && !was_reset) begin
      if (v.rst_at > 0 && O_ppu_wren && !prev_wren && wr_q.size() == v.rst_at) begin
        #1 I_reset = 1'b0;
        #1;
        check($sformatf("v%0d rst halt", idx), O_cpu_halt, 0);
        check($sformatf("v%0d rst wren", idx), O_ppu_wren, 0);
        check($sformatf("v%0d rst busy", idx), O_busy, 0);
        I_reset = 1'b1;
        was_reset = 1;
        @(negedge I_clock);
      end else begin
        tk = ((n % v.period) == 0);
        odd_now = (halt_ticks == 0 && O_busy) ? v.odd : 1'($urandom);
        if (v.disturb > 0 && !disturbed && wr_q.size() == v.disturb) begin
          cyc(tk, 1'b1, 8'h07, odd_now);
          disturbed = 1;
        end else begin
          cyc(tk, 1'b0, 8'($urandom), odd_now);
        end
      end
      n++;
    end
    if (n >= 20000) check($sformatf("v%0d timeout", idx), 1, 0);

    // Reference model: 256 reads of P00..PFF, each byte written once to OAMDATA.
    exp_n     = was_reset ? v.rst_at : 256;
    exp_rd_n  = was_reset ? v.rst_at + 1 : 256;
    exp_ticks = 513 + ((ALIGN && v.odd) ? 1 : 0);
    exp_first = 2 + ((ALIGN && v.odd) ? 1 : 0);
    mism_rd = 0; mism_wr = 0;
    foreach (rd_q[i]) if (rd_q[i] !== {v.page, 8'(i)}) mism_rd++;
    foreach (wr_q[i]) begin
      ea = {v.page, 8'(i)};
      if (wr_q[i] !== {3'd4, mem_fn(ea, v.key)}) mism_wr++;
    end
    check($sformatf("v%0d write count", idx), wr_q.size(), exp_n);
    check($sformatf("v%0d read count", idx), rd_q.size(), exp_rd_n);
    check($sformatf("v%0d read seq mismatches", idx), mism_rd, 0);
    check($sformatf("v%0d write seq mismatches", idx), mism_wr, 0);
    if (!was_reset) begin
      check($sformatf("v%0d halt ticks", idx), halt_ticks, exp_ticks);
      check($sformatf("v%0d first read tick", idx), first_rd, exp_first);
      check($sformatf("v%0d wren clocks", idx), wren_clks, 256 * v.period);
    end
    check($sformatf("v%0d idle halt", idx), O_cpu_halt, 0);
  endtask

  vec_t vecs[12];
  int   k;

  initial begin
    //        page   key    per odd trg dist rst
    vecs[0]  = '{8'h02, 8'h00, 1,  0,  0,  0,   0};
    vecs[1]  = '{8'h02, 8'h5A, 1,  1,  0,  0,   0};
    vecs[2]  = '{8'h02, 8'hA5, 1,  0,  0,  0,   0};
    vecs[3]  = '{8'h03, 8'h00, 1,  0,  0,  10,  0};
    vecs[4]  = '{8'h1F, 8'h3C, 12, 0,  0,  0,   0};
    vecs[5]  = '{8'h44, 8'h00, 1,  0,  0,  0,   100};
    vecs[6]  = '{8'h44, 8'h81, 1,  1,  0,  0,   0};
    vecs[7]  = '{8'hFF, 8'h00, 2,  1,  1,  0,   0};
    for (int i = 8; i < 12; i++)
      vecs[i] = '{8'($urandom), 8'($urandom), int'($urandom_range(1, 3)),
                  1'($urandom), 1'($urandom), 0, 0};

    // Reset values while I_tick is held high.
    I_tick = 1'b1;
    repeat (3) @(negedge I_clock);
    check("reset halt", O_cpu_halt, 0);
    check("reset busy", O_busy, 0);
    check("reset rden", O_mem_rden, 0);
    check("reset wren", O_ppu_wren, 0);
    check("reset mem_addr", O_mem_addr, 16'h0000);
    check("reset ppu_addr", O_ppu_addr, 3'd4);
    check("reset ppu_data", O_ppu_data, 8'h00);
    I_reset = 1'b1;
    I_tick = 1'b0;
    @(negedge I_clock);

    for (int i = 0; i < 12; i++) begin
      run(i, vecs[i]);
      repeat (2) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    end

    // Without ticks the transfer must freeze in HALT.
    halt_ticks = 0; first_rd = -1; prev_wren = O_ppu_wren;
    rd_q.delete(); wr_q.delete();
    cyc(1'b0, 1'b1, 8'h05, 1'b0);
    repeat (40) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("notick busy", O_busy, 1);
    check("notick halt", O_cpu_halt, 1);
    check("notick rden", O_mem_rden, 0);
    check("notick writes", wr_q.size(), 0);
    k = 0;
    while (O_busy && k < 2000) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      k++;
    end
    check("notick resume writes", wr_q.size(), 256);
    check("notick resume last read", rd_q.size() > 0 ? rd_q[rd_q.size()-1] : 16'hxxxx, 16'h05FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
